bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one 32-bit port of the dual-port block RAM among NREQ requesters
//  (CPU, video fetch, DMA, ...). Round-robin arbitration, one access per cycle,
//  optional locked bursts. Returns read data 1 cycle after issue (NOREG BRAM).
//  Sits between the requesters and the clken/addr/we/data_in/data_out of one BRAM port.
// PARAMETERS
//  NREQ       2   number of requesters (2..8)
//  AW        12   word address width (4096 x 32-bit words)
//  MAX_BURST 16   max consecutive locked grants before forced rotation (>=1)
// PORTS
//  clk         in   1         single clock, also drives the BRAM port clock
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   NREQ      request pending, per requester
//  req_lock    in   NREQ      keep port after this access (burst)
//  req_addr    in   NREQ*AW   word address, requester k at [k*AW +: AW]
//  req_we      in   NREQ*4    byte write enables; 0 = read
//  req_wdata   in   NREQ*32   write data, requester k at [k*32 +: 32]
//  req_ready   out  NREQ      one-hot grant; access accepted at clk edge when valid&ready
//  rsp_valid   out  NREQ      one-hot: read data for requester k valid this cycle
//  rsp_rdata   out  32        read data, shared by all requesters
//  mem_clken   out  1         BRAM port clock enable
//  mem_addr    out  AW        BRAM address
//  mem_we      out  4         BRAM byte enables
//  mem_wdata   out  32        BRAM write data
//  mem_rdata   in   32        BRAM data out
// BEHAVIOUR
//  - Reset: rr_ptr=0, owner=none, burst_cnt=0, rsp_valid=0, read tag cleared.
//    Combinational outputs at reset with no requests: req_ready=0, mem_clken=0,
//    mem_we=0, mem_addr=0, mem_wdata=0.
//  - Arbitration (combinational, same cycle): if owner set, only owner eligible;
//    else first k with req_valid[k] searching from rr_ptr upward, wrapping NREQ-1->0.
//  - Winner w: req_ready[w]=1, mem_clken=1, mem_addr/we/wdata = requester w fields.
//    No winner (incl. owner not valid): all req_ready=0, mem_clken=0, mem_* = 0.
//  - Issue at edge t: if mem_we==0, rsp_valid[w]=1 in cycle t+1 with
//    rsp_rdata=mem_rdata; writes produce no response. Back-to-back reads give a
//    response every cycle. rsp_rdata is don't-care when rsp_valid==0.
//  - rr_ptr <= w+1 (mod NREQ) on every unlocked issue.
//  - Lock: issue with req_lock[w]=1 -> owner<=w, burst_cnt<=burst_cnt+1.
//    Owner released (owner<=none, burst_cnt<=0, rr_ptr<=owner+1) when owner
//    issues with req_lock=0, or burst_cnt reaches MAX_BURST (that issue is the
//    last of the burst even if lock still high). Owner idle with lock high:
//    port stays reserved, others stall, burst_cnt does not advance.
//  - Simultaneous equal requests: rr_ptr decides; no requester starves beyond
//    (NREQ-1)*MAX_BURST accepted accesses by others.
//  - Reset mid-burst/mid-read: owner and pending rsp_valid dropped immediately.
// STRUCTURE
//  - Shared package: BRAM_RD_LATENCY=1, BYTE_LANES=4, DATA_W=32.
//  - Sub-module rr_picker: NREQ-wide rotating priority encoder
//    (req vector, start pointer -> one-hot grant + index); used once here.
//  - Registers: rr_ptr, owner_valid, owner_idx, burst_cnt, rsp_tag (one-hot).
// TESTING
//  1 Reset, all req_valid=0 -> mem_clken=0, req_ready=0, rsp_valid=0 for 10 cycles.
//  2 Req0 read addr 0x005 (BRAM preloaded 0xDEADBEEF) -> req_ready[0] same cycle,
//    next cycle rsp_valid=2'b01, rsp_rdata=0xDEADBEEF.
//  3 Both valid continuously, no lock -> grants alternate 0,1,0,1 from reset;
//    responses tagged to matching requester each following cycle.
//  4 Req1 write we=4'b0011 data 0x12345678 to 0x3FF over 0xAAAAAAAA, then read
//    -> no rsp for write; read returns 0xAAAA5678.
//  5 Req0 lock high 40 cycles, req1 valid, MAX_BURST=16 -> 16 grants to req0,
//    then 1 to req1, then req0 again; req1 never waits >16 accepted accesses.
//  6 Reset asserted while req0 owner and read in flight -> rsp_valid=0, owner
//    cleared; after release first grant goes to lowest valid index.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the BRAM port arbiter.
// The BRAM port is a fixed 32-bit, 4-lane, unregistered-output primitive.
package bram_port_arbiter_pkg;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int BYTE_LANES      = 4;
    localparam int DATA_W          = 32;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [BYTE_LANES-1:0] byte_en_t;

endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// Rotating priority encoder: first set request at or above start, wrapping.
// Produces a one-hot grant, the binary index and an any-grant flag.
module bram_port_arbiter_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] N_W = IW'(N);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] rot_wide;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Rotate so that bit 0 of rot is the requester at start.
    assign req_dbl  = {req, req};
    assign rot_wide = req_dbl >> start;
    assign rot      = rot_wide[N-1:0];

    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sum = {1'b0, start} + (IW+1)'(i);
                if (sum >= N_W) begin
                    sum = sum - N_W;
                end
                idx = sum[IW-1:0];
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters, with locked
// bursts capped at MAX_BURST grants and read responses one cycle after issue.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = 12,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*4-1:0]        req_we,
    input  logic [NREQ*32-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     mem_clken,
    output logic [AW-1:0]            mem_addr,
    output logic [3:0]               mem_we,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [IW-1:0]   rr_ptr_reg,      rr_ptr_next;
    logic            owner_valid_reg, owner_valid_next;
    logic [IW-1:0]   owner_idx_reg,   owner_idx_next;
    logic [BW-1:0]   burst_cnt_reg,   burst_cnt_next;
    logic [NREQ-1:0] rsp_tag_reg,     rsp_tag_next;

    logic [AW-1:0]   addr_arr  [NREQ];
    byte_en_t        we_arr    [NREQ];
    word_t           wdata_arr [NREQ];
    logic [NREQ-1:0] eligible;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    logic            grant_any;
    logic            win_lock;
    logic [IW-1:0]   win_ptr_inc;
    logic [BW-1:0]   burst_inc;

    // While a burst owns the port, everyone else is masked out.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign we_arr[gi]    = req_we[gi*BYTE_LANES +: BYTE_LANES];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign eligible[gi]  = req_valid[gi] &
                                   (!owner_valid_reg || (owner_idx_reg == IW'(gi)));
        end
    endgenerate

    bram_port_arbiter_rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_picker (
        .req   (eligible),
        .start (rr_ptr_reg),
        .grant (grant),
        .idx   (win_idx),
        .any   (grant_any)
    );

    assign win_lock    = req_lock[win_idx];
    assign win_ptr_inc = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    assign burst_inc   = burst_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg      <= '0;
            owner_valid_reg <= 1'b0;
            owner_idx_reg   <= '0;
            burst_cnt_reg   <= '0;
            rsp_tag_reg     <= '0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            owner_valid_reg <= owner_valid_next;
            owner_idx_reg   <= owner_idx_next;
            burst_cnt_reg   <= burst_cnt_next;
            rsp_tag_reg     <= rsp_tag_next;
        end
    end

    always_comb begin
        rr_ptr_next      = rr_ptr_reg;
        owner_valid_next = owner_valid_reg;
        owner_idx_next   = owner_idx_reg;
        burst_cnt_next   = burst_cnt_reg;
        rsp_tag_next     = '0;
        if (grant_any) begin
            if (we_arr[win_idx] == '0) begin
                rsp_tag_next = grant;
            end
            // The grant that hits the cap ends the burst even with lock still high.
            if (win_lock && (burst_inc != BURST_MAX)) begin
                owner_valid_next = 1'b1;
                owner_idx_next   = win_idx;
                burst_cnt_next   = burst_inc;
            end else begin
                owner_valid_next = 1'b0;
                burst_cnt_next   = '0;
                rr_ptr_next      = win_ptr_inc;
            end
        end
    end

    always_comb begin
        req_ready = grant;
        mem_clken = grant_any;
        mem_addr  = grant_any ? addr_arr[win_idx]  : '0;
        mem_we    = grant_any ? we_arr[win_idx]    : '0;
        mem_wdata = grant_any ? wdata_arr[win_idx] : '0;
        rsp_valid = rsp_tag_reg;
        rsp_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural unregistered BRAM.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_bram_port_arbiter;

    localparam int NREQ      = 2;
    localparam int AW        = 12;
    localparam int MAX_BURST = 16;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*4-1:0]   req_we;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                mem_clken;
    logic [AW-1:0]       mem_addr;
    logic [3:0]          mem_we;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;

    logic [31:0]         mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_clken (mem_clken),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: read-first, data out one cycle after clken; preloaded during reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h005] <= 32'hDEADBEEF;
            mem[12'h010] <= 32'h1111_1111;
            mem[12'h020] <= 32'h2222_2222;
            mem[12'h3FF] <= 32'hAAAA_AAAA;
        end else if (mem_clken) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic l,
                           input logic [AW-1:0] a, input logic [3:0] we,
                           input logic [31:0] d);
        req_valid[k]           = v;
        req_lock[k]            = l;
        req_addr[k*AW +: AW]   = a;
        req_we[k*4 +: 4]       = we;
        req_wdata[k*32 +: 32]  = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_we    = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] prev_grant;
    int              wait_cnt;
    int              max_wait;

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        repeat (3) next_cycle();
        rst_n = 1'b1;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t1_clken_c%0d", c), 64'(mem_clken), 64'd0);
            check($sformatf("t1_ready_c%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("t1_rspv_c%0d",  c), 64'(rsp_valid), 64'd0);
            next_cycle();
        end
        @(negedge clk);
        check("t1_mem_fields", {mem_we, mem_wdata, 16'(mem_addr)}, 64'd0);
        next_cycle();

        // 2: single read
        set_req(0, 1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        @(negedge clk);
        check("t2_ready", 64'(req_ready), 64'b01);
        check("t2_addr",  64'(mem_addr),  64'h005);
        check("t2_clken", 64'(mem_clken), 64'd1);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check("t2_rspv",  64'(rsp_valid), 64'b01);
        check("t2_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        next_cycle();

        // 3: both requesting, alternating from reset
        do_reset();
        set_req(0, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_grant = (c % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("t3_grant_c%0d", c), 64'(req_ready), 64'(exp_grant));
            if (c > 0) begin
                prev_grant = (c % 2 == 1) ? 2'b01 : 2'b10;
                check($sformatf("t3_rspv_c%0d", c), 64'(rsp_valid), 64'(prev_grant));
                check($sformatf("t3_rdata_c%0d", c), 64'(rsp_rdata),
                      (c % 2 == 1) ? 64'h1111_1111 : 64'h2222_2222);
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();

        // 4: partial write then read back
        do_reset();
        set_req(1, 1'b1, 1'b0, 12'h3FF, 4'b0011, 32'h1234_5678);
        @(negedge clk);
        check("t4_wr_ready", 64'(req_ready), 64'b10);
        check("t4_wr_we",    64'(mem_we),    64'b0011);
        check("t4_wr_data",  64'(mem_wdata), 64'h1234_5678);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 12'h3FF, 4'b0000, 32'h0);
        @(negedge clk);
        check("t4_wr_norsp", 64'(rsp_valid), 64'b00);
        check("t4_rd_ready", 64'(req_ready), 64'b10);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check("t4_rd_rspv",  64'(rsp_valid), 64'b10);
        check("t4_rd_rdata", 64'(rsp_rdata), 64'hAAAA_5678);
        next_cycle();

        // 5: locked burst capped at MAX_BURST, then forced rotation
        do_reset();
        set_req(0, 1'b1, 1'b1, 12'h010, 4'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        wait_cnt = 0;
        max_wait = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp_grant = (c % 17 == 16) ? 2'b10 : 2'b01;
            check($sformatf("t5_grant_c%0d", c), 64'(req_ready), 64'(exp_grant));
            if (req_ready[1]) wait_cnt = 0;
            else if (req_ready[0]) wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
            next_cycle();
        end
        check("t5_max_wait", 64'(max_wait), 64'd16);
        clear_reqs();
        next_cycle();

        // 6: reset while owner holds the port with a read in flight
        do_reset();
        set_req(0, 1'b1, 1'b1, 12'h005, 4'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        @(negedge clk);
        check("t6_owner_grant", 64'(req_ready), 64'b01);
        next_cycle();
        @(negedge clk);
        check("t6_inflight_rspv", 64'(rsp_valid), 64'b01);
        check("t6_owner_hold",    64'(req_ready), 64'b01);
        #2;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 12'h005, 4'h0, 32'h0);
        #1;
        check("t6_rst_rspv",      64'(rsp_valid), 64'b00);
        check("t6_rst_owner_clr", 64'(req_ready), 64'b10);
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        @(negedge clk);
        check("t6_post_grant", 64'(req_ready), 64'b01);
        next_cycle();
        clear_reqs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
